// File: rtl/mp_add_seq_ctrl.sv
// Sequential multi-precision add/subtract controller time-sharing one 16-bit CLA.
// Define MP_ADD_SEQ_OVF_EN to add the registered signed-overflow output ovf.

module cla_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        gm,
  output logic        pm
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  bg;
  logic [3:0]  bp;
  logic        bcar;
  logic        car;

  // Carries look ahead across 4-bit groups and ripple only inside a group.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    s    = '0;
    bcar = cin;
    car  = cin;
    for (int k = 0; k < 4; k++) begin
      bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      bp[k] = &p[4*k +: 4];
    end
    for (int k = 0; k < 4; k++) begin
      car = bcar;
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = p[4*k+j] ^ car;
        car      = g[4*k+j] | (p[4*k+j] & car);
      end
      bcar = bg[k] | (bp[k] & bcar);
    end
    gm = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) | (bp[3] & bp[2] & bp[1] & bg[0]);
    pm = &bp;
  end

endmodule

module mp_add_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MP_ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNKS = WIDTH / 16;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  generate
    if ((WIDTH < 16) || ((WIDTH % 16) != 0)) begin : g_bad_width
      $error("mp_add_seq_ctrl: WIDTH must be a positive multiple of 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            cout_q;
  logic [15:0]     a_q [CHUNKS];
  logic [15:0]     b_q [CHUNKS];
  logic [15:0]     s_q [CHUNKS];
  logic [15:0]     chunk_s;
  logic            chunk_gm;
  logic            chunk_pm;
  logic            chunk_co;
  logic            last;

  assign last     = (cnt == CW'(CHUNKS - 1));
  assign chunk_co = chunk_gm | (chunk_pm & carry);

  cla_16bits u_cla (
    .a   (a_q[cnt]),
    .b   (b_q[cnt]),
    .cin (carry),
    .s   (chunk_s),
    .gm  (chunk_gm),
    .pm  (chunk_pm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MP_ADD_SEQ_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  // Subtract is folded in at capture time: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      for (int i = 0; i < CHUNKS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
`ifdef MP_ADD_SEQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < CHUNKS; i++) begin
              a_q[i] <= a[16*i +: 16];
              b_q[i] <= op_sub ? ~b[16*i +: 16] : b[16*i +: 16];
            end
            carry <= op_sub | cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          s_q[cnt] <= chunk_s;
          carry    <= chunk_co;
          if (last) begin
            cnt    <= '0;
            cout_q <= chunk_co;
`ifdef MP_ADD_SEQ_OVF_EN
            ovf_q  <= a_q[CHUNKS-1][15] ^ b_q[CHUNKS-1][15] ^ chunk_s[15] ^ chunk_co;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_pack
      assign sum[16*gi +: 16] = s_q[gi];
    end
  endgenerate

  assign cout = cout_q;

endmodule

// File: doc/mp_add_seq_ctrl.md
Name: mp_add_seq_ctrl

Overview:
- Sequential multi-precision add/subtract controller that time-multiplexes one instance of the team's 16-bit carry-lookahead adder (cla_16bits) over WIDTH/16 cycles.
- Latches full-width operands, feeds one 16-bit chunk per cycle (LSB first), and forms the chunk carry-out as gm | (pm & carry_in).
- Registers the inter-chunk carry and assembles the result.
- Sits between a requesting datapath and the shared adder, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 64, operand/result width. Must be a multiple of 16 and at least 16; other values are illegal (elaboration error).
- CHUNKS, WIDTH/16, derived localparam, not overridable.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- op_sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when op_sub=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of MSB chunk; for subtract, 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
  - Chunk counter=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b (b inverted if op_sub), and carry=op_sub ? 1 : cin.
  - Set counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, drive chunk[counter] of the latched A/B and the carry register into the cla_16bits instance.
  - Write s into sum[16*counter +: 16].
  - carry <= gm | (pm & carry).
  - counter increments.
  - After the chunk with counter = CHUNKS-1: cout <= final carry, go to DONE.
- DONE:
  - out_valid=1; sum/cout held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
- Latency: acceptance edge to out_valid high = CHUNKS+1 cycles (5 at WIDTH=64). Throughput is one request per CHUNKS+2 cycles minimum.
- No acceptance in RUN or DONE. Inputs a, b, cin and op_sub are don't-care outside the IDLE handshake cycle.
- Backpressure: out_ready low holds DONE indefinitely; sum/cout must not change.
- sum and cout are only meaningful while out_valid=1. Partial chunks may be visible during RUN; the bench must not check them there.
- Wrap-around: the counter is log2(CHUNKS) bits (min 1) and must not advance past CHUNKS-1.
- WIDTH=16 (CHUNKS=1): RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE:
  - Immediate abort, all outputs return to reset values.
  - No result is presented after rst_n deasserts.
- Simultaneous in_valid in DONE with out_ready: the request is not accepted that cycle; it is accepted next cycle in IDLE if still valid.

Optional Feature:
- Macro: MP_ADD_SEQ_OVF_EN.
- With macro:
  - Extra output port ovf (1 bit), reset 0, registered with cout on the last chunk.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, i.e. signed two's-complement overflow of the selected operation.
  - The controller computes the MSB-carry-in from the latched operands and the sum MSB: ovf = a[W-1] ^ b'[W-1] ^ sum[W-1] ^ cout, where b' is the possibly inverted B.
  - Held in DONE like sum.
- Without macro: port and logic absent; behaviour otherwise identical.

Test Plan:
- Add, WIDTH=64: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x0, cout=1. out_valid rises 5 cycles after acceptance; with OVF_EN, ovf=0.
- Sub, WIDTH=64: a=0x0000_0001_0000_0000, b=0x1 -> sum=0x0000_0000_FFFF_FFFF, cout=1. Then a=0x0, b=0x1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0.
- Signed overflow (OVF_EN): a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, add, cin=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum/cout stable, in_ready=0. Raise out_ready -> next cycle IDLE, in_ready=1. A request held on in_valid is accepted then.
- Reset mid-RUN: assert rst_n=0 two cycles after acceptance -> out_valid=0, sum=0, in_ready=1 immediately. No stale out_valid after release.
- Random: 1000 random a/b/cin/op_sub at WIDTH=64 and WIDTH=16 with random out_ready -> sum/cout match reference model every transaction.
